// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory-bus arbiter.
//   - FSM state encoding (IDLE / ISSUE / RESP)
//   - requester IDs (IFU = port 0, LSU = port 1)
//   - default LSU streak limit
//   - helper converting an owner ID into a one-hot port vector
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [0:0] {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int unsigned STREAK_MAX_DEF = 32'd4;

  function automatic logic [1:0] owner_onehot(input req_id_e owner);
    return (owner == REQ_LSU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side bus of the arbiter (IFU = index 0, LSU = index 1).
//   master modport: requesters drive req/addr/wen/wdata/op, see gnt/rvalid/rdata
//   slave  modport: the arbiter
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
);
  logic [1:0]        req_i;
  logic [ADDR_W-1:0] addr_i  [2];
  logic [1:0]        wen_i;
  logic [DATA_W-1:0] wdata_i [2];
  logic [OP_W-1:0]   op_i    [2];
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [DATA_W-1:0] rdata_o;

  modport master (
    output req_i, addr_i, wen_i, wdata_i, op_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, wen_i, wdata_i, op_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/arb_prio2.sv
// arb_prio2: two-input grant logic with LSU priority and an IFU starvation guard.
//   clk, rst_n : clock, async active-low reset
//   req_i[1:0] : bit0 = IFU, bit1 = LSU
//   en_i       : arbiter may grant this cycle
//   gnt_o[1:0] : combinational one-hot (or zero) grant
// The LSU normally wins; once it has won STREAK_MAX times in a row while the
// IFU was waiting, the IFU gets the next grant.
module arb_prio2 #(
  parameter int unsigned STREAK_MAX = 32'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  localparam int unsigned CW = $clog2(STREAK_MAX + 32'd1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STREAK_MAX);

  logic [CW-1:0] streak_cnt_q;
  logic [CW-1:0] streak_cnt_d;
  logic          lsu_wins;

  // Grant selection and streak counter next value.
  always_comb begin
    lsu_wins = req_i[1] && !((streak_cnt_q == CNT_MAX) && req_i[0]);
    if (en_i) begin
      if (lsu_wins) begin
        gnt_o = 2'b10;
      end else if (req_i[0]) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b00;
      end
    end else begin
      gnt_o = 2'b00;
    end

    streak_cnt_d = streak_cnt_q;
    if (gnt_o[0]) begin
      streak_cnt_d = {CW{1'b0}};
    end else if (gnt_o[1]) begin
      // Only LSU wins that actually made the IFU wait count toward the streak.
      if (!req_i[0]) begin
        streak_cnt_d = {CW{1'b0}};
      end else if (streak_cnt_q != CNT_MAX) begin
        streak_cnt_d = streak_cnt_q + CW'(1'b1);
      end else begin
        streak_cnt_d = streak_cnt_q;
      end
    end else begin
      streak_cnt_d = streak_cnt_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_cnt_q <= {CW{1'b0}};
    end else begin
      streak_cnt_q <= streak_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one mmio read/write port between IFU (port 0) and LSU (port 1).
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : requester handshake, payload, grant and response
//   mem_raddr/waddr   : downstream read / write address (latched request)
//   mem_wdata, wdt_op : downstream write data and width code
//   mem_ren, mem_wen  : downstream strobes, only in ISSUE
//   mem_rdata         : downstream read data, combinational from mem_raddr
// Flow: grant (IDLE/RESP) -> ISSUE (strobe) -> RESP (rvalid pulse). RESP can
// grant again, giving one access every two cycles.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 64,
  parameter int          OP_W       = 4,
  parameter int unsigned STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arb_if.slave          bus,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [OP_W-1:0]   wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic              gnt_en;
  logic              sel;

  // rst_n gates the grant so gnt_o stays low while reset is held.
  assign gnt_en = rst_n && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign sel    = gnt[1];

  arb_prio2 #(.STREAK_MAX(STREAK_MAX)) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.req_i),
    .en_i  (gnt_en),
    .gnt_o (gnt)
  );

  // FSM next state, payload latch and response capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (gnt != 2'b00) begin
          state_d = ST_ISSUE;
          owner_d = sel ? REQ_LSU : REQ_IFU;
          wen_d   = bus.wen_i[sel];
          addr_d  = bus.addr_i[sel];
          wdata_d = bus.wdata_i[sel];
          op_d    = bus.op_i[sel];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        // A write completes with an all-zero acknowledge.
        if (wen_q) begin
          rdata_d = {DATA_W{1'b0}};
        end else begin
          rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IFU;
      wen_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      op_q    <= {OP_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/data/op come straight from the latch so they only move on a grant.
  assign mem_raddr    = addr_q;
  assign mem_waddr    = addr_q;
  assign mem_wdata    = wdata_q;
  assign wdt_op       = op_q;
  assign mem_ren      = (state_q == ST_ISSUE) && !wen_q;
  assign mem_wen      = (state_q == ST_ISSUE) && wen_q;
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = (state_q == ST_RESP) ? owner_onehot(owner_q) : 2'b00;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a small downstream RAM.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int OW   = 4;
  localparam int SMAX = 4;

  localparam logic [DW-1:0] RAM_INIT [8] = '{
    64'h0000_0000_0000_1234, 64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0000_0002,
    64'h0BAD_F00D_0000_0003, 64'hCAFE_0000_0000_0004, 64'h5555_AAAA_5555_AAAA,
    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ren, mem_wen;
  logic [OW-1:0] wdt_op;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) bus ();

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .STREAK_MAX(SMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .wdt_op    (wdt_op),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream memory (8 words, index = addr[5:3])
  logic [DW-1:0] ram [8] = RAM_INIT;
  assign mem_rdata = ram[mem_raddr[5:3]];
  always @(posedge clk) if (mem_wen) ram[mem_waddr[5:3]] <= mem_wdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            port;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [OW-1:0] op;
    logic [DW-1:0] rdata;
    int unsigned   t;
  } exp_t;

  exp_t          dq[$];   // expected downstream accesses
  exp_t          rq[$];   // expected responses
  logic [AW-1:0] last_addr;
  bit            mon_en;

  // reference model state
  logic [DW-1:0] mram [8];
  bit            pend [2];
  logic          p_wen [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [OW-1:0] p_op [2];
  int            streak_m;
  bit            busy_m;
  logic [1:0]    dut_gnt;

  // monitor: downstream strobes and responses against the queues
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        chk("strobe_excl", 64'(mem_ren & mem_wen), 64'd0);
        if (dq.size() != 0 && cyc == dq[0].t + 1) begin
          e = dq.pop_front();
          chk("mem_ren", 64'(mem_ren), 64'(!e.wen));
          chk("mem_wen", 64'(mem_wen), 64'(e.wen));
          if (e.wen) begin
            chk("mem_waddr", 64'(mem_waddr), 64'(e.addr));
            chk("mem_wdata", mem_wdata, e.wdata);
          end else begin
            chk("mem_raddr", 64'(mem_raddr), 64'(e.addr));
          end
          chk("wdt_op", 64'(wdt_op), 64'(e.op));
          last_addr = e.addr;
        end else begin
          chk("no_strobe", 64'({mem_ren, mem_wen}), 64'd0);
          chk("addr_hold", 64'(mem_raddr), 64'(last_addr));
        end
        if (rq.size() != 0 && cyc == rq[0].t + 2) begin
          e = rq.pop_front();
          chk("rvalid", 64'(bus.rvalid_o), 64'(2'b01 << e.port));
          chk("rdata", bus.rdata_o, e.rdata);
        end else begin
          chk("no_rvalid", 64'(bus.rvalid_o), 64'd0);
        end
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [OW-1:0] o);
    pend[p] = 1'b1; p_wen[p] = w; p_addr[p] = a; p_wdata[p] = d; p_op[p] = o;
  endtask

  // One cycle: drive pending requests, predict and check the grant.
  task automatic tick();
    logic [1:0] req;
    int         g;
    exp_t       e;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      bus.req_i[p]   = pend[p];
      bus.wen_i[p]   = p_wen[p];
      bus.addr_i[p]  = p_addr[p];
      bus.wdata_i[p] = p_wdata[p];
      bus.op_i[p]    = p_op[p];
    end
    req = {pend[1], pend[0]};
    #1;
    dut_gnt = bus.gnt_o;
    g = -1;
    if (!busy_m && req != 2'b00) begin
      if (req[1] && !(streak_m == SMAX && req[0])) g = 1;
      else g = 0;
    end
    chk("gnt", 64'(dut_gnt), (g < 0) ? 64'd0 : 64'(2'b01 << g));
    if (g >= 0) begin
      e.port = g; e.wen = p_wen[g]; e.addr = p_addr[g]; e.wdata = p_wdata[g];
      e.op = p_op[g]; e.t = cyc;
      e.rdata = p_wen[g] ? 64'd0 : mram[p_addr[g][5:3]];
      if (p_wen[g]) mram[p_addr[g][5:3]] = p_wdata[g];
      dq.push_back(e);
      rq.push_back(e);
      if (g == 0) streak_m = 0;
      else if (req[0]) streak_m = (streak_m < SMAX) ? streak_m + 1 : SMAX;
      else streak_m = 0;
      pend[g] = 1'b0;
      busy_m = 1'b1;
    end else begin
      busy_m = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    logic [2:0]  idx;
    r   = $urandom();
    idx = 3'($urandom_range(7, 0));
    return {r[31:6], idx, 3'b000};
  endfunction

  task automatic rand_issue(input int p);
    logic [31:0] lo, hi;
    lo = $urandom(); hi = $urandom();
    issue(p, 1'($urandom_range(1, 0)), rand_addr(), {hi, lo}, 4'($urandom_range(15, 0)));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n_lsu;
    int ifu_at;
    bit chk_streak;
    rst_n = 1'b0; mon_en = 1'b0; last_addr = '0; streak_m = 0; busy_m = 1'b0;
    for (int i = 0; i < 8; i++) mram[i] = RAM_INIT[i];
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_wen[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; p_op[p] = '0;
      bus.addr_i[p] = '0; bus.wdata_i[p] = '0; bus.op_i[p] = '0;
    end
    bus.wen_i = 2'b00;
    bus.req_i = 2'b11;   // requests held during reset must not be granted
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("rst_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    chk("rst_rdata", bus.rdata_o, 64'd0);
    chk("rst_raddr", 64'(mem_raddr), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_op", 64'(wdt_op), 64'd0);
    chk("rst_streak", 64'(dut.u_prio.streak_cnt_q), 64'd0);
    @(negedge clk);
    bus.req_i = 2'b00;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single IFU read of 0x8000_0000 (RAM word 0x1234)
    issue(0, 1'b0, 32'h8000_0000, 64'd0, 4'h3);
    tick(); chk("ifu_read_gnt", 64'(dut_gnt), 64'h1);
    tick(); tick();

    // LSU write 0xAB, then read it back through the IFU
    issue(1, 1'b1, 32'h1000_0008, 64'hAB, 4'h0);
    tick(); chk("lsu_write_gnt", 64'(dut_gnt), 64'h2);
    tick(); tick();
    issue(0, 1'b0, 32'h1000_0008, 64'd0, 4'h3);
    tick(); tick(); tick();

    // simultaneous requests: LSU first, IFU in the RESP cycle
    issue(0, 1'b0, 32'h0000_0010, 64'd0, 4'h2);
    issue(1, 1'b0, 32'h0000_0018, 64'd0, 4'h3);
    tick(); chk("simul_first", 64'(dut_gnt), 64'h2);
    tick(); chk("simul_gap", 64'(dut_gnt), 64'h0);
    tick(); chk("simul_second", 64'(dut_gnt), 64'h1);
    tick(); tick();

    // starvation guard: LSU keeps requesting for 6 grants while IFU waits
    issue(0, 1'b0, 32'h0000_0020, 64'd0, 4'h1);
    n_lsu = 0; ifu_at = -1; chk_streak = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!pend[1] && n_lsu < 6) rand_issue(1);
      tick();
      if (chk_streak) begin
        chk("streak_clear", 64'(dut.u_prio.streak_cnt_q), 64'd0);
        chk_streak = 1'b0;
      end
      if (dut_gnt == 2'b10) n_lsu++;
      if (dut_gnt == 2'b01 && ifu_at < 0) begin
        ifu_at = n_lsu;
        chk_streak = 1'b1;
      end
    end
    chk("starve_lsu_before_ifu", 64'(ifu_at), 64'd4);
    chk("starve_lsu_total", 64'(n_lsu), 64'd6);

    // reset during ISSUE drops the access
    issue(0, 1'b0, 32'h0000_0030, 64'd0, 4'h3);
    tick(); chk("mid_rst_gnt", 64'(dut_gnt), 64'h1);
    @(posedge clk); #3;
    chk("mid_rst_issue", 64'(mem_ren), 64'd1);
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    chk("mid_rst_ren", 64'(mem_ren), 64'd0);
    chk("mid_rst_wen", 64'(mem_wen), 64'd0);
    chk("mid_rst_raddr", 64'(mem_raddr), 64'd0);
    dq.delete(); rq.delete();
    busy_m = 1'b0; streak_m = 0; last_addr = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    bus.req_i = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rvalid", 64'(bus.rvalid_o), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    issue(0, 1'b0, 32'h0000_0030, 64'd0, 4'h3);
    tick(); chk("post_rst_gnt", 64'(dut_gnt), 64'h1);
    tick(); tick();

    // random traffic, including legal payload changes before the grant
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(2, 0) != 0) rand_issue(p);
        end else if ($urandom_range(3, 0) == 0) begin
          rand_issue(p);
        end
      end
      tick();
    end
    for (int k = 0; k < 10; k++) tick();
    chk("drain_pend", 64'({pend[1], pend[0]}), 64'd0);
    chk("drain_dq", 64'(dq.size()), 64'd0);
    chk("drain_rq", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
